// File: rtl/boot_loader_if.sv
// Signal bundle between the boot loader and its UART pair / instruction-memory write port.
// master is the loader side; slave is the UART/memory environment side.
interface boot_loader_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  rx_ready;
  logic [7:0]            rdata;
  logic                  ferr;
  logic                  tx_busy;
  logic                  tx_start;
  logic [7:0]            sdata;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  done;
  logic                  overflow;
  logic                  rx_error;

  modport master (
    input  rx_ready, rdata, ferr, tx_busy,
    output tx_start, sdata, imem_we, imem_addr, imem_wdata, done, overflow, rx_error
  );

  modport slave (
    output rx_ready, rdata, ferr, tx_busy,
    input  tx_start, sdata, imem_we, imem_addr, imem_wdata, done, overflow, rx_error
  );
endinterface

// File: rtl/boot_loader.sv
// Power-up program loader: requests a program over the UART, packs received bytes
// into 32-bit little-endian words for instruction memory, acknowledges, then releases the core.
//
// state      | meaning
// SEND_REQ   | wait for idle transmitter, send BOOT_REQ
// SIZE       | collect 4-byte little-endian program size
// PROG       | pack program bytes, write each completed word
// FLUSH      | write trailing partial word (upper lanes zero)
// SEND_ACK   | wait for idle transmitter, send BOOT_ACK
// WAIT_ACK   | wait for the ACK transmit to finish
// DONE       | load complete, receiver ignored until reset
module boot_loader #(
  parameter int         ADDR_WIDTH = 14,
  parameter logic [7:0] BOOT_REQ   = 8'h99,
  parameter logic [7:0] BOOT_ACK   = 8'haa
) (
  input  logic          clock,
  input  logic          reset,
  boot_loader_if.master bus
);

  localparam logic [2:0] S_SEND_REQ = 3'd0;
  localparam logic [2:0] S_SIZE     = 3'd1;
  localparam logic [2:0] S_PROG     = 3'd2;
  localparam logic [2:0] S_FLUSH    = 3'd3;
  localparam logic [2:0] S_SEND_ACK = 3'd4;
  localparam logic [2:0] S_WAIT_ACK = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]            state_q, state_d;
  logic                  tx_start_q, tx_start_d;
  logic [7:0]            sdata_q, sdata_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  done_q, done_d;
  logic                  overflow_q, overflow_d;
  logic                  rx_error_q, rx_error_d;
  logic [31:0]           size_q, size_d;
  logic [1:0]            size_idx_q, size_idx_d;
  logic [31:0]           byte_cnt_q, byte_cnt_d;
  logic [31:0]           word_q, word_d;
  // one extra bit so the address can reach 2^ADDR_WIDTH and flag capacity exhaustion
  logic [ADDR_WIDTH:0]   waddr_q, waddr_d;
  logic                  seen_busy_q, seen_busy_d;

  logic        good_byte;
  logic        bad_byte;
  logic        do_write;
  logic [31:0] wr_word;
  logic [31:0] size_full;
  logic [1:0]  lane;

  assign good_byte = bus.rx_ready & ~bus.ferr;
  assign bad_byte  = bus.rx_ready & bus.ferr;
  assign lane      = byte_cnt_q[1:0];

  always_comb begin
    state_d      = state_q;
    tx_start_d   = 1'b0;
    sdata_d      = sdata_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    done_d       = done_q;
    overflow_d   = overflow_q;
    rx_error_d   = rx_error_q;
    size_d       = size_q;
    size_idx_d   = size_idx_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    waddr_d      = waddr_q;
    seen_busy_d  = seen_busy_q;
    do_write     = 1'b0;
    wr_word      = word_q;
    size_full    = {bus.rdata, size_q[23:0]};

    case (state_q)
      S_SEND_REQ: begin
        if (!bus.tx_busy && !tx_start_q) begin
          tx_start_d = 1'b1;
          sdata_d    = BOOT_REQ;
          size_idx_d = 2'd0;
          state_d    = S_SIZE;
        end
      end
      S_SIZE: begin
        if (bad_byte) begin
          rx_error_d = 1'b1;
        end else if (good_byte) begin
          size_d[{size_idx_q, 3'b000} +: 8] = bus.rdata;
          size_idx_d = size_idx_q + 2'd1;
          if (size_idx_q == 2'd3) begin
            byte_cnt_d = 32'd0;
            waddr_d    = '0;
            state_d    = (size_full == 32'd0) ? S_SEND_ACK : S_PROG;
          end
        end
      end
      S_PROG: begin
        if (bad_byte) begin
          rx_error_d = 1'b1;
        end else if (good_byte) begin
          if (lane == 2'd0) word_d = {24'd0, bus.rdata};
          else              word_d[{lane, 3'b000} +: 8] = bus.rdata;
          byte_cnt_d = byte_cnt_q + 32'd1;
          if (lane == 2'd3) begin
            do_write = 1'b1;
            wr_word  = word_d;
          end
          if (byte_cnt_d == size_q)
            state_d = (size_q[1:0] != 2'd0) ? S_FLUSH : S_SEND_ACK;
        end
      end
      S_FLUSH: begin
        do_write = 1'b1;
        wr_word  = word_q;
        state_d  = S_SEND_ACK;
      end
      S_SEND_ACK: begin
        if (!bus.tx_busy && !tx_start_q) begin
          tx_start_d  = 1'b1;
          sdata_d     = BOOT_ACK;
          seen_busy_d = 1'b0;
          state_d     = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        // busy only rises after the strobe, so require having seen it high first
        if (bus.tx_busy) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = S_SEND_REQ;
      end
    endcase

    if (do_write) begin
      if (waddr_q[ADDR_WIDTH]) begin
        overflow_d = 1'b1;
      end else begin
        imem_we_d    = 1'b1;
        imem_addr_d  = waddr_q[ADDR_WIDTH-1:0];
        imem_wdata_d = wr_word;
        waddr_d      = waddr_q + (ADDR_WIDTH+1)'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_SEND_REQ;
      tx_start_q   <= 1'b0;
      sdata_q      <= 8'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      rx_error_q   <= 1'b0;
      size_q       <= 32'd0;
      size_idx_q   <= 2'd0;
      byte_cnt_q   <= 32'd0;
      word_q       <= 32'd0;
      waddr_q      <= '0;
      seen_busy_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_start_q   <= tx_start_d;
      sdata_q      <= sdata_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      rx_error_q   <= rx_error_d;
      size_q       <= size_d;
      size_idx_q   <= size_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      waddr_q      <= waddr_d;
      seen_busy_q  <= seen_busy_d;
    end
  end

  assign bus.tx_start   = tx_start_q;
  assign bus.sdata      = sdata_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.done       = done_q;
  assign bus.overflow   = overflow_q;
  assign bus.rx_error   = rx_error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: table of complete loads plus hand sequences for busy gating,
// empty-program ACK latency and reset in the middle of a program.
module tb_boot_loader;

  typedef struct {
    logic [31:0]     size;
    int              nb;
    logic [8*24-1:0] bytes;
    logic [23:0]     fm;
    bit              use_b;
    int              nw;
    logic [32*6-1:0] w;
    bit              ovf;
    bit              rxe;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_ready = 1'b0;
  logic       ferr = 1'b0;
  logic [7:0] rdata = 8'd0;
  logic       force_busy = 1'b0;
  int         busy_a = 0;
  int         busy_b = 0;
  int         cyc = 0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  boot_loader_if #(.ADDR_WIDTH(14)) ifa ();
  boot_loader_if #(.ADDR_WIDTH(2))  ifb ();

  assign ifa.rx_ready = rx_ready;
  assign ifa.rdata    = rdata;
  assign ifa.ferr     = ferr;
  assign ifa.tx_busy  = force_busy || (busy_a != 0);
  assign ifb.rx_ready = rx_ready;
  assign ifb.rdata    = rdata;
  assign ifb.ferr     = ferr;
  assign ifb.tx_busy  = force_busy || (busy_b != 0);

  boot_loader #(.ADDR_WIDTH(14)) dut_a (.clock(clk), .reset(rst), .bus(ifa));
  boot_loader #(.ADDR_WIDTH(2))  dut_b (.clock(clk), .reset(rst), .bus(ifb));

  // UartTx model: busy rises the cycle after tx_start and lasts 5 cycles
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) busy_a <= 0;
    else if (ifa.tx_start) busy_a <= 5;
    else if (busy_a != 0) busy_a <= busy_a - 1;
    if (rst) busy_b <= 0;
    else if (ifb.tx_start) busy_b <= 5;
    else if (busy_b != 0) busy_b <= busy_b - 1;
  end

  logic [63:0] wq_a[$], wq_b[$];
  logic [7:0]  tq_a[$], tq_b[$];
  int   bad_tx = 0;
  int   fall_a = 0, fall_b = 0, dlat_a = 0, dlat_b = 0;
  logic pb_a = 0, pd_a = 0, ps_a = 0, pb_b = 0, pd_b = 0, ps_b = 0;

  always @(negedge clk) begin
    if (rst) begin
      wq_a.delete(); wq_b.delete(); tq_a.delete(); tq_b.delete();
    end else begin
      if (ifa.imem_we) wq_a.push_back({32'(ifa.imem_addr), ifa.imem_wdata});
      if (ifb.imem_we) wq_b.push_back({32'(ifb.imem_addr), ifb.imem_wdata});
      if (ifa.tx_start) begin
        tq_a.push_back(ifa.sdata);
        if (ps_a || ifa.tx_busy) bad_tx++;
      end
      if (ifb.tx_start) begin
        tq_b.push_back(ifb.sdata);
        if (ps_b || ifb.tx_busy) bad_tx++;
      end
      if (pb_a && !ifa.tx_busy) fall_a = cyc;
      if (pb_b && !ifb.tx_busy) fall_b = cyc;
      if (ifa.done && !pd_a) dlat_a = cyc - fall_a;
      if (ifb.done && !pd_b) dlat_b = cyc - fall_b;
    end
    pb_a = ifa.tx_busy; pd_a = ifa.done; ps_a = ifa.tx_start;
    pb_b = ifb.tx_busy; pd_b = ifb.done; ps_b = ifb.tx_start;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic f);
    rx_ready = 1'b1;
    rdata    = b;
    ferr     = f;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    ferr     = 1'b0;
    rdata    = 8'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_ready = 1'b0;
    ferr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_tx_a(input string nm, input int n);
    for (int c = 0; c < 100; c++) begin
      if (tq_a.size() >= n) break;
      idle(1);
    end
    chk(nm, 64'(tq_a.size() >= n), 64'd1);
  endtask

  task automatic send_size(input logic [31:0] s);
    for (int k = 0; k < 4; k++) begin
      send_byte(s[8*k +: 8], 1'b0);
      idle(1);
    end
  endtask

  function automatic logic [63:0] outs_a();
    return 64'({ifa.tx_start, ifa.sdata, ifa.imem_we, ifa.imem_addr, ifa.imem_wdata,
                ifa.done, ifa.overflow, ifa.rx_error});
  endfunction

  vec_t        vecs[6];
  logic [63:0] wq[$];
  logic [7:0]  tq[$];
  logic        dsel, osel, esel;
  int          dlat;
  int          n;

  initial begin
    for (int i = 0; i < 6; i++) begin
      vecs[i].size = 0; vecs[i].nb = 0; vecs[i].bytes = '0; vecs[i].fm = '0;
      vecs[i].use_b = 0; vecs[i].nw = 0; vecs[i].w = '0; vecs[i].ovf = 0; vecs[i].rxe = 0;
    end
    for (int k = 0; k < 24; k++) begin
      vecs[0].bytes[8*k +: 8] = 8'(k + 1);
      vecs[4].bytes[8*k +: 8] = 8'(k);
      vecs[5].bytes[8*k +: 8] = 8'(8'h10 + k);
    end
    // normal load
    vecs[0].size = 8; vecs[0].nb = 8; vecs[0].nw = 2;
    vecs[0].w[31:0] = 32'h04030201; vecs[0].w[63:32] = 32'h08070605;
    // partial word
    vecs[1].size = 5; vecs[1].nb = 5; vecs[1].nw = 2;
    vecs[1].bytes[39:0] = 40'hEE_DD_CC_BB_AA;
    vecs[1].w[31:0] = 32'hDDCCBBAA; vecs[1].w[63:32] = 32'h000000EE;
    // empty program
    vecs[2].size = 0;
    // framing error on second program byte
    vecs[3].size = 4; vecs[3].nb = 5; vecs[3].fm = 24'h2; vecs[3].rxe = 1; vecs[3].nw = 1;
    vecs[3].bytes[39:0] = 40'h55_44_33_22_11;
    vecs[3].w[31:0] = 32'h55443311;
    // overflow on the 4-word instance
    vecs[4].size = 20; vecs[4].nb = 20; vecs[4].use_b = 1; vecs[4].nw = 4; vecs[4].ovf = 1;
    vecs[4].w[31:0] = 32'h03020100; vecs[4].w[63:32] = 32'h07060504;
    vecs[4].w[95:64] = 32'h0B0A0908; vecs[4].w[127:96] = 32'h0F0E0D0C;
    // 7 bytes: one full word and a 3-byte flush
    vecs[5].size = 7; vecs[5].nb = 7; vecs[5].nw = 2;
    vecs[5].w[31:0] = 32'h13121110; vecs[5].w[63:32] = 32'h00161514;

    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", outs_a(), 64'd0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      wait_tx_a($sformatf("v%0d req seen", i), 1);
      send_size(vecs[i].size);
      for (int k = 0; k < vecs[i].nb; k++) send_byte(vecs[i].bytes[8*k +: 8], vecs[i].fm[k]);
      for (int c = 0; c < 400; c++) begin
        if (vecs[i].use_b ? ifb.done : ifa.done) break;
        idle(1);
      end
      idle(2);
      send_byte(8'h5A, 1'b0);
      idle(3);
      if (vecs[i].use_b) begin
        wq = wq_b; tq = tq_b; dsel = ifb.done; osel = ifb.overflow; esel = ifb.rx_error; dlat = dlat_b;
      end else begin
        wq = wq_a; tq = tq_a; dsel = ifa.done; osel = ifa.overflow; esel = ifa.rx_error; dlat = dlat_a;
      end
      chk($sformatf("v%0d done", i), 64'(dsel), 64'd1);
      chk($sformatf("v%0d done latency", i), 64'(dlat), 64'd1);
      chk($sformatf("v%0d tx count", i), 64'(tq.size()), 64'd2);
      if (tq.size() == 2) begin
        chk($sformatf("v%0d tx req", i), 64'(tq[0]), 64'h99);
        chk($sformatf("v%0d tx ack", i), 64'(tq[1]), 64'hAA);
      end
      chk($sformatf("v%0d write count", i), 64'(wq.size()), 64'(vecs[i].nw));
      for (int k = 0; k < vecs[i].nw && k < wq.size(); k++)
        chk($sformatf("v%0d write %0d", i, k), wq[k], {32'(k), vecs[i].w[32*k +: 32]});
      chk($sformatf("v%0d overflow", i), 64'(osel), 64'(vecs[i].ovf));
      chk($sformatf("v%0d rx_error", i), 64'(esel), 64'(vecs[i].rxe));
    end

    // transmitter busy at start defers the request
    force_busy = 1'b1;
    do_reset();
    idle(10);
    chk("busy defers req", 64'(tq_a.size()), 64'd0);
    force_busy = 1'b0;
    wait_tx_a("req after busy", 1);
    if (tq_a.size() >= 1) chk("req byte after busy", 64'(tq_a[0]), 64'h99);

    // empty program: ACK strobe follows the 4th size byte directly
    do_reset();
    wait_tx_a("empty req", 1);
    idle(8);
    for (int k = 0; k < 4; k++) send_byte(8'h00, 1'b0);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (ifa.tx_start) break;
      n++;
      idle(1);
    end
    chk("empty ack latency", 64'(n), 64'd1);
    chk("empty ack byte", 64'(ifa.sdata), 64'hAA);

    // reset in the middle of a program
    do_reset();
    wait_tx_a("midreset req", 1);
    send_size(32'd8);
    send_byte(8'hC1, 1'b0);
    send_byte(8'hEE, 1'b1);
    send_byte(8'hC2, 1'b0);
    send_byte(8'hC3, 1'b0);
    chk("midreset rx_error set", 64'(ifa.rx_error), 64'd1);
    chk("midreset no write yet", 64'(wq_a.size()), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset outputs", outs_a(), 64'd0);
    rst = 1'b0;
    wait_tx_a("midreset new req", 1);
    if (tq_a.size() >= 1) chk("midreset new req byte", 64'(tq_a[0]), 64'h99);
    send_size(32'd4);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0);
    send_byte(8'hA4, 1'b0);
    chk("write latency we", 64'(ifa.imem_we), 64'd1);
    chk("write latency addr/data", {32'(ifa.imem_addr), ifa.imem_wdata}, {32'd0, 32'hA4A3A2A1});
    for (int c = 0; c < 100; c++) begin
      if (ifa.done) break;
      idle(1);
    end
    chk("reload done", 64'(ifa.done), 64'd1);
    chk("reload write count", 64'(wq_a.size()), 64'd1);
    chk("reload overflow clear", 64'(ifa.overflow), 64'd0);

    chk("tx_start pulse/busy rule", 64'(bad_tx), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/boot_loader.md
# boot_loader

CPU-side program loader that owns the UART receiver/transmitter pair at power-up. It announces readiness with 0x99, receives a 4-byte little-endian program size and then the program bytes, and packs them into 32-bit words written to instruction memory. It then acknowledges with 0xaa and raises `done` to release the core. It sits between `UartRx`/`UartTx` and the instruction-memory write port inside `top`.

## Interface
- `ADDR_WIDTH`, default 14: instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.
- `BOOT_REQ`, default 8'h99: byte sent to request a program.
- `BOOT_ACK`, default 8'haa: byte sent after the load completes.

Ports:
- `clock`  in  1  sole clock; everything is sampled on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_ready`  in  1  one-cycle strobe from `UartRx`; `rdata` is valid in that cycle.
- `rdata`  in  8  received byte.
- `ferr`  in  1  frame error flag, qualified by `rx_ready`.
- `tx_busy`  in  1  `UartTx` busy; it rises the cycle after `tx_start`.
- `tx_start`  out  1  one-cycle transmit strobe.
- `sdata`  out  8  byte to transmit; held stable while `tx_start` is high.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `imem_addr`  out  ADDR_WIDTH  word address.
- `imem_wdata`  out  32  packed word.
- `done`  out  1  load complete; stays high until reset.
- `overflow`  out  1  sticky; program exceeded capacity.
- `rx_error`  out  1  sticky; a byte arrived with `ferr` high.

## Operation
- State machine: SEND_REQ → SIZE → PROG → FLUSH → SEND_ACK → WAIT_ACK → DONE.
- **SEND_REQ:** when `tx_busy` is low and `tx_start` is low, pulse `tx_start` with `sdata` = BOOT_REQ. Next state is SIZE.
- **SIZE:** capture 4 bytes on `rx_ready`, little-endian (first byte → size[7:0]). After the 4th byte:
  - size == 0 → SEND_ACK.
  - otherwise → PROG, with byte counter = 0 and word address = 0.
- **PROG:** each accepted byte shifts into the word assembly register at lane (byte_count mod 4), little-endian.
  - On lane 3, issue a write and increment the word address.
  - When byte_count reaches size, the next state is FLUSH if size mod 4 ≠ 0, else SEND_ACK.
- **FLUSH:** write the partial word with the unfilled upper lanes zero. Next state is SEND_ACK.
- **SEND_ACK:** pulse `tx_start` with BOOT_ACK under the same rule as SEND_REQ. Next state is WAIT_ACK.
- **WAIT_ACK:** wait until `tx_busy` falls, then go to DONE.
- **DONE:** `done` = 1. All `rx_ready` strobes are ignored.
- **Frame errors:** a byte with `ferr` = 1 is discarded (not counted, not written) and sets `rx_error`.
- **Capacity:** writes whose word address would be ≥ 2^ADDR_WIDTH are suppressed; `imem_we` stays low and `overflow` is set. Byte counting continues so the protocol stays in sync.
- **Counter widths:** byte counter 32 bits; `imem_addr` has ADDR_WIDTH bits and does not wrap, because writes are suppressed instead.
- `rx_ready` strobes in SEND_REQ, SEND_ACK and WAIT_ACK are ignored.

## Timing
- **Reset values:** `tx_start`=0, `sdata`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `done`=0, `overflow`=0, `rx_error`=0, state = SEND_REQ.
- **Request byte:** the first `tx_start` occurs no earlier than the cycle after reset deasserts, and not while `tx_busy` is high.
- **Strobes:** `tx_start` is high for exactly one cycle per byte. There are exactly two transmits per load (one BOOT_REQ, one BOOT_ACK).
- **Write latency:** `imem_we` rises in the cycle after the `rx_ready` of a word's 4th byte. `imem_addr` and `imem_wdata` are valid in that same cycle.
- **Back-to-back bytes:** `rx_ready` on consecutive cycles must be accepted without loss.
- **FLUSH:** lasts one cycle and produces one `imem_we`.
- **Done:** `done` rises in the cycle after `tx_busy` falls following the ACK transmit.
- **Reset mid-operation:** (any state) returns everything to reset values. The next load starts with a fresh BOOT_REQ; no partial word is written.

## Test plan
- **Normal load:** size 8, bytes 01 02 … 08 → writes addr 0 = 0x04030201 and addr 1 = 0x08070605. Then one `tx_start` with 0xaa, then `done` = 1.
- **Partial word:** size 5, bytes AA BB CC DD EE → addr 0 = 0xDDCCBBAA; FLUSH writes addr 1 = 0x000000EE. Exactly 2 writes.
- **Empty program:** size 0 → no `imem_we`; 0xaa is sent immediately after the 4th size byte.
- **Overflow:** ADDR_WIDTH = 2, size 20 → 4 writes (addr 0–3); the 5th is suppressed. `overflow` = 1, ACK is still sent, `done` = 1.
- **Framing error and busy gating:** one program byte with `ferr` = 1 → discarded, `rx_error` = 1, the next good byte fills the same lane. `tx_busy` held high at start → `tx_start` is deferred until it drops.
- **Reset mid-PROG:** pulse `reset` after 3 program bytes → all outputs return to 0; a new 0x99 is sent; a subsequent full load writes from addr 0.
